b16_io_responder: RTL and testbench
===================================

Name: b16_io_responder

Overview:
- Memory-mapped peripheral that answers the b16 CPU data bus: decodes a 16-byte window and serves reads and byte-lane writes.
- Holds eight word registers covering a GPIO port, a 16-bit timer with compare interrupt, and an 8N1 UART transmitter with a small TX FIFO.
- Sits beside program RAM on the b16 bus. Its rdata is zero outside the window, so the system can OR it into the CPU data input.

Parameters:
- BASE, 16'hFFF0, byte base address of the window; bits [3:0] must be 0.
- FDEP, 2, log2 of TX FIFO depth (4 entries).
- DIV_RST, 16'd0, reset value of the baud divisor.

Ports:
- clk  in  1  clock; all state updates on posedge.
- nreset  in  1  reset, asynchronous, active-low.
- addr  in  16  byte address from CPU.
- rd  in  1  read strobe.
- wr  in  2  byte-lane write strobes; wr[1] = bits 15:8, wr[0] = bits 7:0.
- wdata  in  16  write data, already lane-aligned by the CPU.
- rdata  out  16  read data; combinational.
- hit  out  1  addr is inside the window.
- gpio_in  in  8  asynchronous inputs.
- gpio_out  out  8  GPIO outputs.
- txd  out  1  UART serial output; idle high.
- irq  out  1  level interrupt.

Behaviour:
- Decode: hit = (addr[15:4] == BASE[15:4]). Word index n = addr[3:1]. addr[0] is ignored; byte selection comes only from wr, and the CPU does byte extraction on reads.
- Reads: rdata = selected register when rd & hit, else 16'h0000. Reads have no side effects; the CPU asserts rd speculatively during fetch. Unused bits read 0.
- Writes: on posedge, when hit & |wr, each lane updates only the bits it covers.
- Register map:
  - 0 GPIO_OUT: rw [7:0]; wr[0] only.
  - 1 GPIO_IN: ro [7:0]; 2-flop synchronizer, so a read sees input 2 cycles late.
  - 2 TIMER: rw 16-bit. Increments by 1 every cycle and wraps FFFF->0000. In a write cycle the written lanes load wdata and there is no increment; an unwritten lane keeps its pre-increment value.
  - 3 CMP: rw 16-bit.
  - 4 CTRL: rw; [0] timer irq enable, [1] tx-empty irq enable.
  - 5 STATUS:
    - [0] TFLAG, W1C via wr[0].
    - [1] fifo full, ro.
    - [2] tx idle (fifo empty & FSM IDLE), ro.
    - [3] OVF, W1C.
    - [FDEP+4:4] fifo count, ro.
  - 6 TXDATA: wo, reads 0. A wr[0] write pushes wdata[7:0]; wr[1]-only writes are ignored.
  - 7 DIV: rw 16-bit; bit time = DIV+1 cycles.
- TFLAG set: in the cycle TIMER's next value equals CMP, including a value loaded by a write. Set wins over a simultaneous W1C.
- irq = (CTRL[0] & TFLAG) | (CTRL[1] & STATUS[2]); registered, so it follows its sources by 1 cycle.
- FIFO push:
  - Full is evaluated before any same-cycle pop.
  - A push when full is dropped and sets OVF; set wins over a simultaneous W1C.
- UART TX FSM: states IDLE, START, DATA, STOP.
  - IDLE -> START when the fifo is non-empty: pop the head into the shift register, txd=0, load the bit counter.
  - START lasts DIV+1 cycles, then -> DATA.
  - DATA shifts 8 bits LSB first, each DIV+1 cycles.
  - STOP holds txd=1 for DIV+1 cycles, then -> IDLE, or straight to START if the fifo is non-empty (back-to-back frames with no idle gap).
  - DIV is sampled at each bit start. Changing DIV mid-frame affects the next bit only.
- Reset values: gpio_out=0, TIMER=0, CMP=16'hFFFF, CTRL=0, TFLAG=0, OVF=0, fifo empty, DIV=DIV_RST, FSM IDLE, txd=1, irq=0, synchronizer=0.
- Reset asserted mid-frame aborts it: txd returns to 1 asynchronously and fifo contents are lost.
- A read and a write in the same cycle cannot occur on this bus and need not be handled.

Test Plan:
- Release reset, rd each word 0..7 at BASE -> rdata 0000, 0000, 0000 (+ cycles counted), FFFF, 0000, 0004, 0000, DIV_RST. Reading addr 16'hFFE0 -> 0000, hit=0.
- Write GPIO_OUT wr=2'b01 wdata=16'h12A5 -> gpio_out=A5. Then wr=2'b10 wdata=16'hFF00 -> gpio_out unchanged A5.
- TIMER write 16'h0010, CMP=16'h0014, CTRL=1 -> TFLAG set when TIMER goes 0013->0014, irq 1 cycle later. W1C in that same set cycle -> flag stays 1. W1C a cycle later -> irq drops.
- DIV=3, push 8'hA5 -> txd low 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4 cycles. STATUS[2] returns 1 and irq fires with CTRL=2.
- DIV=0, push 6 bytes back-to-back -> first pops immediately, next 4 fill the fifo (full=1), 6th dropped with OVF=1. Exactly 5 frames on txd with no idle gap.
- Assert nreset during DATA bit 3 -> txd=1 immediately. After release fifo count=0, FSM IDLE, no partial frame resumes.

Source files
------------

// File: rtl/b16_io_responder.sv
// b16_io_responder: b16 data-bus peripheral with GPIO, compare timer and an 8N1 UART transmitter.
// rdata is zero outside the 16-byte window so it can be ORed with program RAM data.
module b16_io_responder #(
    parameter logic [15:0] BASE    = 16'hFFF0,
    parameter int          FDEP    = 2,
    parameter logic [15:0] DIV_RST = 16'd0
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic [15:0] addr,
    input  logic        rd,
    input  logic [1:0]  wr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        hit,
    input  logic [7:0]  gpio_in,
    output logic [7:0]  gpio_out,
    output logic        txd,
    output logic        irq
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    localparam int DEPTH = 1 << FDEP;

    state_t          state;
    logic [7:0]      sync1, sync2, shreg;
    logic [15:0]     timer, cmp, div, bcnt, timer_nx;
    logic [1:0]      ctrl;
    logic            tflag, ovf;
    logic [7:0]      fifo [DEPTH];
    logic [FDEP-1:0] wptr, rptr;
    logic [FDEP:0]   count;
    logic [2:0]      n, bitn;
    logic            w0, w1, full, empty, tx_idle, push, pop, timer_wr;
    logic            unused_ok;

    assign hit      = addr[15:4] == BASE[15:4];
    assign n        = addr[3:1];
    assign w0       = hit & wr[0];
    assign w1       = hit & wr[1];
    assign full     = count[FDEP];
    assign empty    = count == '0;
    assign tx_idle  = empty & (state == IDLE);
    assign push     = w0 & (n == 3'd6);
    assign pop      = ~empty & ((state == IDLE) | ((state == STOP) & (bcnt == '0)));
    assign timer_wr = (w0 | w1) & (n == 3'd2);
    // a written timer lane loads wdata, the other lane holds its pre-increment value
    assign timer_nx = timer_wr ? {w1 ? wdata[15:8] : timer[15:8], w0 ? wdata[7:0] : timer[7:0]}
                               : timer + 16'd1;
    assign unused_ok = addr[0];

    always_comb begin
        rdata = '0;
        if (rd & hit)
            case (n)
                3'd0:    rdata = {8'h00, gpio_out};
                3'd1:    rdata = {8'h00, sync2};
                3'd2:    rdata = timer;
                3'd3:    rdata = cmp;
                3'd4:    rdata = {14'h0000, ctrl};
                3'd5:    rdata = {{(11 - FDEP){1'b0}}, count, ovf, tx_idle, full, tflag};
                3'd7:    rdata = div;
                default: rdata = '0;
            endcase
    end

    always_ff @(posedge clk or negedge nreset)
        if (!nreset) begin
            gpio_out <= '0;
            sync1    <= '0;
            sync2    <= '0;
            timer    <= '0;
            cmp      <= 16'hFFFF;
            ctrl     <= '0;
            tflag    <= 1'b0;
            ovf      <= 1'b0;
            div      <= DIV_RST;
            irq      <= 1'b0;
        end else begin
            sync1 <= gpio_in;
            sync2 <= sync1;
            timer <= timer_nx;
            // flag sets win over a simultaneous write-one-to-clear
            tflag <= (timer_nx == cmp) | (tflag & ~(w0 & (n == 3'd5) & wdata[0]));
            ovf   <= (push & full) | (ovf & ~(w0 & (n == 3'd5) & wdata[3]));
            irq   <= (ctrl[0] & tflag) | (ctrl[1] & tx_idle);
            if (w0 & (n == 3'd0)) gpio_out <= wdata[7:0];
            if (w0 & (n == 3'd4)) ctrl <= wdata[1:0];
            if (w0 & (n == 3'd3)) cmp[7:0] <= wdata[7:0];
            if (w1 & (n == 3'd3)) cmp[15:8] <= wdata[15:8];
            if (w0 & (n == 3'd7)) div[7:0] <= wdata[7:0];
            if (w1 & (n == 3'd7)) div[15:8] <= wdata[15:8];
        end

    always_ff @(posedge clk)
        if (push & ~full) fifo[wptr] <= wdata[7:0];

    always_ff @(posedge clk or negedge nreset)
        if (!nreset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push & ~full) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            count <= count + {{FDEP{1'b0}}, push & ~full} - {{FDEP{1'b0}}, pop};
        end

    // bcnt counts down the current bit; DIV is resampled at every bit start
    always_ff @(posedge clk or negedge nreset)
        if (!nreset) begin
            state <= IDLE;
            txd   <= 1'b1;
            shreg <= '0;
            bitn  <= '0;
            bcnt  <= '0;
        end else
            case (state)
                IDLE:
                    if (pop) begin
                        state <= START;
                        txd   <= 1'b0;
                        shreg <= fifo[rptr];
                        bcnt  <= div;
                    end
                START:
                    if (bcnt == '0) begin
                        state <= DATA;
                        txd   <= shreg[0];
                        shreg <= {1'b0, shreg[7:1]};
                        bitn  <= '0;
                        bcnt  <= div;
                    end else
                        bcnt <= bcnt - 16'd1;
                DATA:
                    if (bcnt == '0) begin
                        bcnt <= div;
                        if (bitn == 3'd7) begin
                            state <= STOP;
                            txd   <= 1'b1;
                        end else begin
                            txd   <= shreg[0];
                            shreg <= {1'b0, shreg[7:1]};
                            bitn  <= bitn + 3'd1;
                        end
                    end else
                        bcnt <= bcnt - 16'd1;
                STOP:
                    if (bcnt == '0) begin
                        if (pop) begin
                            state <= START;
                            txd   <= 1'b0;
                            shreg <= fifo[rptr];
                            bcnt  <= div;
                        end else
                            state <= IDLE;
                    end else
                        bcnt <= bcnt - 16'd1;
                default: state <= IDLE;
            endcase
endmodule

// File: tb/tb_b16_io_responder.sv
// tb_b16_io_responder: directed scenarios plus random bus traffic checked every cycle
// against a behavioural model of the register file, FIFO and serial frames.
module tb_b16_io_responder;
    localparam logic [15:0] BASE    = 16'hFFF0;
    localparam logic [15:0] DIV_RST = 16'd0;

    logic        clk = 1'b0, nreset = 1'b0, rd = 1'b0;
    logic [1:0]  wr = 2'b00;
    logic [15:0] addr = 16'h0000, wdata = 16'h0000, rdata;
    logic [7:0]  gpio_in = 8'h00, gpio_out;
    logic        hit, txd, irq;
    int          n_chk = 0, n_fail = 0;
    bit          chk_on = 1'b0;

    b16_io_responder #(.BASE(BASE), .FDEP(2), .DIV_RST(DIV_RST)) dut (
        .clk(clk), .nreset(nreset), .addr(addr), .rd(rd), .wr(wr), .wdata(wdata),
        .rdata(rdata), .hit(hit), .gpio_in(gpio_in), .gpio_out(gpio_out),
        .txd(txd), .irq(irq)
    );

    always #5 clk = ~clk;

    logic [7:0]  m_gpio, m_s1, m_s2;
    logic [15:0] m_timer, m_cmp, m_div;
    logic [1:0]  m_ctrl;
    logic        m_tflag, m_ovf, m_irq, m_busy;
    logic [7:0]  m_fifo[$];
    logic [9:0]  m_frame;
    int          m_bit, m_left;

    function automatic logic m_hit(input logic [15:0] a);
        return int'(a) >= int'(BASE) && int'(a) <= int'(BASE) + 15;
    endfunction

    function automatic logic m_idle();
        return !m_busy && m_fifo.size() == 0;
    endfunction

    function automatic logic m_txd();
        return m_busy ? m_frame[m_bit] : 1'b1;
    endfunction

    function automatic logic [15:0] m_rdata();
        int sz;
        sz = m_fifo.size();
        if (!(rd && m_hit(addr))) return 16'h0000;
        case (addr[3:1])
            3'd0: return {8'h00, m_gpio};
            3'd1: return {8'h00, m_s2};
            3'd2: return m_timer;
            3'd3: return m_cmp;
            3'd4: return {14'h0000, m_ctrl};
            3'd5: return 16'(sz * 16 + (m_ovf ? 8 : 0) + (m_idle() ? 4 : 0) + (sz == 4 ? 2 : 0) + (m_tflag ? 1 : 0));
            3'd7: return m_div;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic model_reset();
        m_gpio = 8'h00; m_s1 = 8'h00; m_s2 = 8'h00;
        m_timer = 16'h0000; m_cmp = 16'hFFFF; m_div = DIV_RST; m_ctrl = 2'b00;
        m_tflag = 1'b0; m_ovf = 1'b0; m_irq = 1'b0; m_busy = 1'b0;
        m_fifo.delete();
        m_frame = 10'h3FF; m_bit = 0; m_left = 0;
    endtask

    // one clock edge, computed from the state and bus inputs as they were just before it
    task automatic model_step();
        logic h, w0, w1, push;
        logic [2:0] n;
        logic [15:0] tnx;
        int sz, od;
        h = m_hit(addr); n = addr[3:1]; w0 = h && wr[0]; w1 = h && wr[1];
        sz = m_fifo.size(); od = int'(m_div);
        push = w0 && n == 3'd6;
        m_irq = (m_ctrl[0] && m_tflag) || (m_ctrl[1] && m_idle());
        tnx = m_timer + 16'd1;
        if (n == 3'd2 && (w0 || w1)) begin
            tnx = m_timer;
            if (w0) tnx[7:0] = wdata[7:0];
            if (w1) tnx[15:8] = wdata[15:8];
        end
        m_tflag = (tnx == m_cmp) || (m_tflag && !(n == 3'd5 && w0 && wdata[0]));
        m_ovf = (push && sz == 4) || (m_ovf && !(n == 3'd5 && w0 && wdata[3]));
        m_timer = tnx;
        if (w0 && n == 3'd0) m_gpio = wdata[7:0];
        if (w0 && n == 3'd4) m_ctrl = wdata[1:0];
        if (w0 && n == 3'd3) m_cmp[7:0] = wdata[7:0];
        if (w1 && n == 3'd3) m_cmp[15:8] = wdata[15:8];
        if (w0 && n == 3'd7) m_div[7:0] = wdata[7:0];
        if (w1 && n == 3'd7) m_div[15:8] = wdata[15:8];
        m_s2 = m_s1; m_s1 = gpio_in;
        if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_bit++;
                if (m_bit == 10) m_busy = 1'b0;
                else m_left = od + 1;
            end
        end
        if (!m_busy && sz > 0) begin
            m_frame = {1'b1, m_fifo.pop_front(), 1'b0};
            m_busy = 1'b1; m_bit = 0; m_left = od + 1;
        end
        if (push && sz < 4) m_fifo.push_back(wdata[7:0]);
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk)
        if (chk_on) begin
            chk("rdata", rdata, m_rdata());
            chk("hit", 16'(hit), 16'(m_hit(addr)));
            chk("gpio_out", 16'(gpio_out), 16'(m_gpio));
            chk("txd", 16'(txd), 16'(m_txd()));
            chk("irq", 16'(irq), 16'(m_irq));
        end

    task automatic tick(input logic r, input logic [1:0] w, input logic [15:0] a, input logic [15:0] d);
        rd = r; wr = w; addr = a; wdata = d;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic wreg(input int n, input logic [1:0] w, input logic [15:0] d);
        tick(1'b0, w, BASE + 16'(2 * n), d);
    endtask

    task automatic idle(input int k);
        repeat (k) tick(1'b0, 2'b00, 16'h0000, 16'h0000);
    endtask

    task automatic rchk(input string name, input int n, input logic [15:0] exp);
        rd = 1'b1; wr = 2'b00; addr = BASE + 16'(2 * n);
        #1;
        chk(name, rdata, exp);
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        int n, k;
        logic [15:0] a, d;
        logic [9:0] fr;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        nreset = 1'b1;
        chk_on = 1'b1;

        rchk("rst_gpio_out", 0, 16'h0000);
        rchk("rst_gpio_in", 1, 16'h0000);
        rchk("rst_timer", 2, 16'h0002);
        rchk("rst_cmp", 3, 16'hFFFF);
        rchk("rst_ctrl", 4, 16'h0000);
        rchk("rst_status", 5, 16'h0004);
        rchk("rst_txdata", 6, 16'h0000);
        rchk("rst_div", 7, DIV_RST);
        rd = 1'b1; addr = 16'hFFE0;
        #1;
        chk("outside_rdata", rdata, 16'h0000);
        chk("outside_hit", 16'(hit), 16'h0000);
        idle(1);

        wreg(0, 2'b01, 16'h12A5);
        chk("gpio_lo_write", 16'(gpio_out), 16'h00A5);
        wreg(0, 2'b10, 16'hFF00);
        chk("gpio_hi_ignored", 16'(gpio_out), 16'h00A5);
        gpio_in = 8'h3C;
        rchk("sync_0", 1, 16'h0000);
        rchk("sync_1", 1, 16'h0000);
        rchk("sync_2", 1, 16'h003C);

        wreg(2, 2'b11, 16'h0010);
        wreg(3, 2'b11, 16'h0014);
        wreg(4, 2'b01, 16'h0001);
        idle(1);
        wreg(5, 2'b01, 16'h0001);
        chk("irq_lags_flag", 16'(irq), 16'h0000);
        rchk("tflag_set_wins", 5, 16'h0005);
        chk("irq_timer", 16'(irq), 16'h0001);
        wreg(5, 2'b01, 16'h0001);
        chk("irq_after_w1c", 16'(irq), 16'h0001);
        idle(1);
        chk("irq_cleared", 16'(irq), 16'h0000);
        wreg(4, 2'b01, 16'h0000);

        wreg(7, 2'b11, 16'h0003);
        wreg(6, 2'b01, 16'h00A5);
        idle(1);
        fr = {1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < 40; i++) begin
            chk("frame_a5", 16'(txd), 16'(fr[i / 4]));
            idle(1);
        end
        rchk("tx_done_status", 5, 16'h0004);
        wreg(4, 2'b01, 16'h0002);
        idle(1);
        chk("irq_tx_empty", 16'(irq), 16'h0001);
        wreg(4, 2'b01, 16'h0000);

        wreg(7, 2'b11, 16'h0000);
        for (int i = 1; i <= 6; i++) wreg(6, 2'b01, 16'(i * 17));
        rchk("burst_status", 5, 16'h004A);
        k = 0;
        rd = 1'b1; wr = 2'b00; addr = BASE + 16'd10;
        #1;
        while (!rdata[2] && k < 200) begin
            @(posedge clk);
            model_step();
            #1;
            k++;
        end
        chk("burst_len", 16'(k), 16'd45);
        wreg(5, 2'b01, 16'h0008);
        rchk("ovf_cleared", 5, 16'h0004);

        wreg(7, 2'b11, 16'h0003);
        wreg(6, 2'b01, 16'h0037);
        wreg(6, 2'b01, 16'h0048);
        idle(16);
        chk("pre_reset_bit3", 16'(txd), 16'h0000);
        rd = 1'b0; wr = 2'b00;
        nreset = 1'b0;
        model_reset();
        #1;
        chk("reset_txd", 16'(txd), 16'h0001);
        repeat (2) @(posedge clk);
        #1;
        nreset = 1'b1;
        rchk("post_reset_status", 5, 16'h0004);
        rchk("post_reset_div", 7, DIV_RST);
        for (int i = 0; i < 30; i++) begin
            chk("no_resume", 16'(txd), 16'h0001);
            idle(1);
        end

        for (int i = 0; i < 3000; i++) begin
            n = $urandom_range(0, 7);
            a = BASE + 16'(2 * n) + 16'($urandom_range(0, 1));
            d = 16'($urandom);
            if ($urandom_range(0, 7) == 0) a = 16'($urandom);
            if (i % 16 == 0) gpio_in = 8'($urandom);
            if (n == 7) d = d & 16'h0003;
            if (n == 3) d = m_timer + 16'($urandom_range(2, 30));
            case ($urandom_range(0, 3))
                0: tick(1'b1, 2'b00, a, d);
                1: tick(1'b0, 2'b00, a, d);
                default: tick(1'b0, 2'($urandom_range(1, 3)), a, d);
            endcase
        end
        idle(60);
        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
